// File: rtl/sar_search8.sv
// Successive-approximation search: drives a magnitude comparator's `a` operand and
// binary-searches the unknown `b`. Optional early exit on `eq` via SAR_EARLY_EXIT_EN.
module sar_search8 #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic [WIDTH-1:0]           guess,
    input  logic                       gr,
    input  logic                       eq,
    input  logic                       le,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [WIDTH-1:0]           result,
    output logic [$clog2(WIDTH+1)-1:0] iter,
    output logic                       state_dbg
);

    localparam int IW = $clog2(WIDTH + 1);
    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [IW-1:0]    ITER_ONE   = IW'(1);
    localparam logic [KW-1:0]    K_ONE      = KW'(1);
    localparam logic [KW-1:0]    K_TOP      = KW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] GUESS_INIT = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        IDLE  = 1'b0,
        PROBE = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] guess_r, guess_n;
    logic [WIDTH-1:0] result_r, result_n;
    logic [KW-1:0]    k, k_n;
    logic [IW-1:0]    iter_r, iter_n;
    logic             busy_r, busy_n;
    logic             done_r, done_n;
    logic             err_r, err_n;
    logic [WIDTH-1:0] trial;
    logic             onehot;

    // A legal verdict has exactly one of gr/eq/le set.
    assign onehot = (gr & ~eq & ~le) | (~gr & eq & ~le) | (~gr & ~eq & le);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            guess_r  <= '0;
            result_r <= '0;
            k        <= '0;
            iter_r   <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state    <= state_n;
            guess_r  <= guess_n;
            result_r <= result_n;
            k        <= k_n;
            iter_r   <= iter_n;
            busy_r   <= busy_n;
            done_r   <= done_n;
            err_r    <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        guess_n  = guess_r;
        result_n = result_r;
        k_n      = k;
        iter_n   = iter_r;
        busy_n   = busy_r;
        done_n   = 1'b0;
        err_n    = err_r;
        trial    = guess_r;

        case (state)
            IDLE: begin
                if (start) begin
                    guess_n  = GUESS_INIT;
                    k_n      = K_TOP;
                    iter_n   = '0;
                    err_n    = 1'b0;
                    result_n = '0;
                    busy_n   = 1'b1;
                    state_n  = PROBE;
                end
            end
            PROBE: begin
                iter_n = iter_r + ITER_ONE;
                if (!onehot) begin
                    // Broken verdict: abandon and report the trial as it stood.
                    err_n    = 1'b1;
                    done_n   = 1'b1;
                    result_n = guess_r;
                    busy_n   = 1'b0;
                    state_n  = IDLE;
                end
`ifdef SAR_EARLY_EXIT_EN
                else if (eq) begin
                    result_n = guess_r;
                    done_n   = 1'b1;
                    busy_n   = 1'b0;
                    state_n  = IDLE;
                end
`endif
                else begin
                    if (gr) begin
                        trial[k] = 1'b0;
                    end
                    if (k != '0) begin
                        trial[k - K_ONE] = 1'b1;
                        k_n              = k - K_ONE;
                        guess_n          = trial;
                    end else begin
                        // Last bit resolved: guess now equals the target.
                        guess_n  = trial;
                        result_n = trial;
                        done_n   = 1'b1;
                        busy_n   = 1'b0;
                        state_n  = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign guess     = guess_r;
    assign result    = result_r;
    assign iter      = iter_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign state_dbg = state;

endmodule
